// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and writeback mux select encodings
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 4;
    localparam int WB_CNT_W  = 4;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/wb_starve_counter.sv
// rtl/wb_starve_counter.sv - saturating lost-contention counter with clear/hold and limit flag
module wb_starve_counter
    import wb_pkg::*;
#(
    parameter int LIMIT = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam logic [WB_CNT_W-1:0] LIMIT_C = WB_CNT_W'(LIMIT);

    logic [WB_CNT_W-1:0] r_count;

    // Clear beats increment; neither asserted means hold (used during stalls).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LIMIT_C)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_limit = (r_count == LIMIT_C);

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - two-requester register-file writeback arbiter with starvation guard
// Optional round-robin default policy: WB_PORT_ARBITER_ROUND_ROBIN_EN
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int ADDR_W       = WB_ADDR_W,
    parameter int STARVE_LIMIT = 3,
    parameter int R0_ZERO      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              wb_stall,
    output logic              wb_sel,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data
);

    logic              w_active;
    logic              w_starve0;
    logic              w_starve1;
    logic              w_default_mem;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_xfer;
    logic              w_sel_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic [DATA_W-1:0] w_data_next;
    logic              w_write_zero;
    logic              w_inc0;
    logic              w_clr0;
    logic              w_inc1;
    logic              w_clr1;

    logic              r_wb_en;
    logic              r_wb_sel;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;

    assign w_active = !rst && !wb_stall;

`ifdef WB_PORT_ARBITER_ROUND_ROBIN_EN
    logic r_last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= WB_SEL_ALU;
        end else if (w_xfer) begin
            r_last_grant <= w_sel_next;
        end
    end

    // Favour whichever requester did not win last; reset value hands req1 the first contention.
    assign w_default_mem = (r_last_grant == WB_SEL_ALU);
`else
    assign w_default_mem = 1'b1;
`endif

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_active) begin
            if (req0_valid && req1_valid) begin
                if (w_starve1) begin
                    w_grant1 = 1'b1;
                end else if (w_starve0) begin
                    w_grant0 = 1'b1;
                end else if (w_default_mem) begin
                    w_grant1 = 1'b1;
                end else begin
                    w_grant0 = 1'b1;
                end
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign w_xfer      = w_grant0 || w_grant1;
    assign w_sel_next  = w_grant1 ? WB_SEL_MEM : WB_SEL_ALU;
    assign w_addr_next = w_grant1 ? req1_addr : req0_addr;
    assign w_data_next = w_grant1 ? req1_data : req0_data;

    // Writes to r0 still complete the handshake so the requester is not blocked.
    assign w_write_zero = (R0_ZERO != 0) && (w_addr_next == '0);

    assign w_inc0 = w_active && req0_valid && w_grant1;
    assign w_clr0 = w_active && (!req0_valid || w_grant0);
    assign w_inc1 = w_active && req1_valid && w_grant0;
    assign w_clr1 = w_active && (!req1_valid || w_grant1);

    wb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve0 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_inc      (w_inc0),
        .i_clr      (w_clr0),
        .o_at_limit (w_starve0)
    );

    wb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve1 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_inc      (w_inc1),
        .i_clr      (w_clr1),
        .o_at_limit (w_starve1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_en   <= 1'b0;
            r_wb_sel  <= WB_SEL_ALU;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (w_xfer) begin
            r_wb_en   <= !w_write_zero;
            r_wb_sel  <= w_sel_next;
            r_wb_addr <= w_addr_next;
            r_wb_data <= w_data_next;
        end else begin
            r_wb_en   <= 1'b0;
        end
    end

    assign wb_en   = r_wb_en;
    assign wb_sel  = r_wb_sel;
    assign wb_addr = r_wb_addr;
    assign wb_data = r_wb_data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter against a behavioural model
module tb_wb_port_arbiter;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int LIM = 3;
    localparam int R0Z = 1;
`ifdef WB_PORT_ARBITER_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          wb_stall = 1'b0;
    logic          wb_sel;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    wb_port_arbiter #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .STARVE_LIMIT (LIM),
        .R0_ZERO      (R0Z)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wb_stall   (wb_stall),
        .wb_sel     (wb_sel),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r0;
        logic r1;
    } rdy_t;

    typedef struct {
        logic          en;
        logic          sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } out_t;

    rdy_t q_rdy[$];
    out_t q_out[$];

    int checks = 0;
    int errors = 0;

    // Model state: lost-contention streaks, last winner, expected register outputs.
    int   m_wait[2] = '{0, 0};
    int   m_last    = 0;
    out_t m_cur     = '{1'b0, 1'b0, '0, '0};
    out_t m_pend    = '{1'b0, 1'b0, '0, '0};
    bit   m_pend_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q_rdy.size() > 0) begin
            rdy_t r;
            r = q_rdy.pop_front();
            chk("req0_ready", 32'(req0_ready), 32'(r.r0));
            chk("req1_ready", 32'(req1_ready), 32'(r.r1));
        end
        if (q_out.size() > 0) begin
            out_t o;
            o = q_out.pop_front();
            chk("wb_en",   32'(wb_en),   32'(o.en));
            chk("wb_sel",  32'(wb_sel),  32'(o.sel));
            chk("wb_addr", 32'(wb_addr), 32'(o.addr));
            chk("wb_data", 32'(wb_data), 32'(o.data));
        end
    end

    task automatic drive(input logic t_rst, input logic t_stall,
                         input logic t_v0, input logic [AW-1:0] t_a0, input logic [DW-1:0] t_d0,
                         input logic t_v1, input logic [AW-1:0] t_a1, input logic [DW-1:0] t_d1);
        int   g;
        int   pref;
        bit   v[2];
        rdy_t r;
        @(posedge clk);
        #1;
        if (m_pend_valid) begin
            q_out.push_back(m_pend);
            m_cur = m_pend;
        end
        rst = t_rst; wb_stall = t_stall;
        req0_valid = t_v0; req0_addr = t_a0; req0_data = t_d0;
        req1_valid = t_v1; req1_addr = t_a1; req1_data = t_d1;

        v[0] = t_v0;
        v[1] = t_v1;
        g = -1;
        if (!t_rst && !t_stall) begin
            if (v[0] && v[1]) begin
                pref = (RR_EN && m_last == 1) ? 0 : 1;
                if (m_wait[1] >= LIM)      g = 1;
                else if (m_wait[0] >= LIM) g = 0;
                else                       g = pref;
            end else if (v[0]) begin
                g = 0;
            end else if (v[1]) begin
                g = 1;
            end
        end
        r.r0 = (g == 0);
        r.r1 = (g == 1);
        q_rdy.push_back(r);

        m_pend = m_cur;
        if (t_rst) begin
            m_pend = '{1'b0, 1'b0, '0, '0};
            m_wait = '{0, 0};
            m_last = 0;
        end else if (!t_stall) begin
            for (int i = 0; i < 2; i++) begin
                if (v[i] && g == 1 - i) m_wait[i] = (m_wait[i] + 1 > LIM) ? LIM : m_wait[i] + 1;
                else                    m_wait[i] = 0;
            end
            m_pend.en = 1'b0;
            if (g >= 0) begin
                m_last      = g;
                m_pend.sel  = (g == 1);
                m_pend.addr = (g == 1) ? t_a1 : t_a0;
                m_pend.data = (g == 1) ? t_d1 : t_d0;
                m_pend.en   = !(R0Z != 0 && m_pend.addr == '0);
            end
        end else begin
            m_pend.en = 1'b0;
        end
        m_pend_valid = 1'b1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 4'd5, 16'h1234, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            drive(0, 0, 1, 4'd2, 16'hA000 + 16'(i), 1, 4'd3, 16'hB000 + 16'(i));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 4'd6, 16'h0606, 1, 4'd7, 16'h0707);
        drive(0, 1, 1, 4'd6, 16'h0606, 1, 4'd7, 16'h0707);
        drive(0, 1, 1, 4'd6, 16'h0606, 1, 4'd7, 16'h0707);
        drive(0, 0, 1, 4'd6, 16'h0606, 1, 4'd7, 16'h0707);
        drive(0, 0, 1, 4'd6, 16'h0606, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 4'd0, 16'hFFFF, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 4'd9, 16'h5A5A, 0, 0, 0);
        drive(1, 0, 1, 4'd9, 16'h6B6B, 1, 4'd10, 16'h7C7C);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            drive(0, 0, 1, 4'd9, 16'h1100 + 16'(i), 1, 4'd9, 16'h2200 + 16'(i));
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 75, AW'($urandom), DW'($urandom),
                  $urandom_range(0, 99) < 75, AW'($urandom), DW'($urandom));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
